// File: rtl/exponential.sv
`default_nettype none
// ============================================================================
// Module   : exponential
// Purpose  : Iterative e^x for x in [0,1) via truncated Taylor series on one
//            shared 16x16 multiplier; 2.16 result. Optional macro EXP_ROUND_EN
//            selects round-to-nearest products and reciprocal table.
// Revision : 1.0 - initial release
// ============================================================================
module exponential #(
    parameter int TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        done,
    output logic [1:0]  int_part,
    output logic [15:0] frac_part
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_REL = 3'd1,
        S_MUL_X    = 3'd2,
        S_MUL_R    = 3'd3,
        S_FIN      = 3'd4
    } state_t;

    localparam logic [3:0] c_last_i = 4'(TERMS - 1);

`ifdef EXP_ROUND_EN
    localparam logic [31:0] c_round = 32'h0000_8000;
`else
    localparam logic [31:0] c_round = 32'h0000_0000;
`endif

    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_t;
    logic [17:0] r_s;
    logic [3:0]  r_i;

    logic [15:0] w_mul_b;
    logic [31:0] w_prod;
    logic [15:0] w_t_next;

    // Reciprocal table R[i] = 65536/i, truncated or rounded to nearest.
    function automatic logic [15:0] recip(input logic [3:0] idx);
        logic [15:0] r;
        r = 16'd0;
        case (idx)
            4'd2:  r = 16'd32768;
            4'd3:  r = 16'd21845;
            4'd4:  r = 16'd16384;
            4'd5:  r = 16'd13107;
`ifdef EXP_ROUND_EN
            4'd6:  r = 16'd10923;
            4'd9:  r = 16'd7282;
            4'd10: r = 16'd6554;
            4'd11: r = 16'd5958;
`else
            4'd6:  r = 16'd10922;
            4'd9:  r = 16'd7281;
            4'd10: r = 16'd6553;
            4'd11: r = 16'd5957;
`endif
            4'd7:  r = 16'd9362;
            4'd8:  r = 16'd8192;
            4'd12: r = 16'd5461;
            4'd13: r = 16'd5041;
            4'd14: r = 16'd4681;
            4'd15: r = 16'd4369;
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    // One multiplier serves both steps: T*X in MUL_X, T*R[i] in MUL_R.
    assign w_mul_b  = (r_state == S_MUL_X) ? r_x : recip(r_i);
    assign w_prod   = 32'(r_t) * 32'(w_mul_b) + c_round;
    assign w_t_next = w_prod[31:16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_x       <= 16'd0;
            r_t       <= 16'd0;
            r_s       <= 18'd0;
            r_i       <= 4'd0;
            done      <= 1'b0;
            int_part  <= 2'd0;
            frac_part <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT_REL;
                        done    <= 1'b0;
                    end
                end
                S_WAIT_REL: begin
                    // Launch on release of start; x is captured only here.
                    if (!start) begin
                        r_x     <= x;
                        r_t     <= x;
                        r_s     <= {2'b01, x};
                        r_i     <= 4'd2;
                        r_state <= S_MUL_X;
                    end
                end
                S_MUL_X: begin
                    r_t     <= w_t_next;
                    r_state <= S_MUL_R;
                end
                S_MUL_R: begin
                    r_t <= w_t_next;
                    r_s <= r_s + {2'b00, w_t_next};
                    if (r_i == c_last_i) begin
                        r_state <= S_FIN;
                    end else begin
                        r_i     <= r_i + 4'd1;
                        r_state <= S_MUL_X;
                    end
                end
                S_FIN: begin
                    int_part  <= r_s[17:16];
                    frac_part <= r_s[15:0];
                    done      <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exponential.sv
`default_nettype none
// Scoreboard bench for exponential: driver queues expected results on release
// of start; an independent monitor checks each rising done against the queue.
module tb_exponential;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = 16'd0;
    logic        done;
    logic [1:0]  int_part;
    logic [15:0] frac_part;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string name;
        int    int_exp;
        int    lo;
        int    hi;
        int    edge0;
    } exp_t;

    exp_t sb[$];

    exponential #(.TERMS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .done      (done),
        .int_part  (int_part),
        .frac_part (frac_part)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            if (lo == hi)
                $display("FAIL %s: got %0d, expected %0d", nm, act, lo);
            else
                $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Monitor: a rising done pops one expected result and checks value + latency.
    initial begin : monitor
        logic pd;
        exp_t e;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && done && !pd) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_int"}, int'(int_part), e.int_exp, e.int_exp);
                    check({e.name, "_frac"}, int'(frac_part), e.lo, e.hi);
                    check({e.name, "_latency"}, cyc - e.edge0, 13, 13);
                end
            end
            pd = done;
        end
    end

    // Launch one computation; exact value for the truncating build, spec band otherwise.
    task automatic launch(input string nm, input logic [15:0] x_first, input logic [15:0] x_rel,
                          input int hold, input int int_exp, input int exact,
                          input int lo, input int hi);
        exp_t e;
        @(negedge clk);
        x     = x_first;
        start = 1'b1;
        @(negedge clk);
        check({nm, "_done_cleared"}, int'(done), 0, 0);
        repeat (hold - 1) @(negedge clk);
        x     = x_rel;
        start = 1'b0;
        e.name    = nm;
        e.int_exp = int_exp;
`ifdef EXP_ROUND_EN
        e.lo = lo;
        e.hi = hi;
`else
        e.lo = exact;
        e.hi = exact;
`endif
        e.edge0 = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string nm, input bit toggle);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            if (toggle) x = 16'($urandom);
            k++;
        end
        if (sb.size() != 0) begin
            check({nm, "_timeout"}, 1, 0, 0);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_done", int'(done), 0, 0);
        check("reset_int", int'(int_part), 0, 0);
        check("reset_frac", int'(frac_part), 0, 0);
        repeat (5) @(negedge clk);
        check("idle_done", int'(done), 0, 0);

        launch("x0000", 16'h0000, 16'h0000, 5, 1, 0, 0, 0);
        wait_result("x0000", 1'b0);

        launch("x4000", 16'h4000, 16'h4000, 1, 1, 18612, 18606, 18614);
        wait_result("x4000", 1'b0);
        repeat (5) @(negedge clk);
        check("x4000_done_held", int'(done), 1, 1);
        check("x4000_frac_held", int'(frac_part), 18606, 18614);

        launch("x2000", 16'h1234, 16'h2000, 3, 1, 8725, 8718, 8726);
        wait_result("x2000", 1'b0);

        launch("xFFFF", 16'hFFFF, 16'hFFFF, 2, 2, 47064, 47060, 47073);
        wait_result("xFFFF", 1'b1);

        // Abort: reset asserted just after edge 6 of a running computation.
        launch("abort", 16'h4000, 16'h4000, 1, 1, 18612, 18606, 18614);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_done", int'(done), 0, 0);
        check("abort_int", int'(int_part), 0, 0);
        check("abort_frac", int'(frac_part), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", int'(done), 0, 0);

        launch("x4000_again", 16'h4000, 16'h4000, 2, 1, 18612, 18606, 18614);
        wait_result("x4000_again", 1'b0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exponential.md
Name: exponential

Overview:
- Sequential fixed-point engine that computes e^x for an unsigned fractional input x in [0, 1).
- Uses a truncated Taylor series, sum of x^i/i! for i = 0 .. TERMS-1, evaluated iteratively on one shared 16x16 multiplier.
- Result is a 2.16 fixed-point value, presented as a 2-bit integer part and a 16-bit fraction.
- Standalone arithmetic block driven by a controller through a start/done handshake.

Parameters:
- TERMS, default 8: number of series terms (x^0 .. x^(TERMS-1)); legal range 3..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; a computation is launched on its release (see Behaviour).
- x  input  16  operand, unsigned 0.16 fraction (value = x/65536).
- done  output  1  high while int_part/frac_part hold a completed result.
- int_part  output  2  integer part of e^x (1 or 2 for legal inputs).
- frac_part  output  16  fractional part of e^x, 0.16 format.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - done=0, int_part=0, frac_part=0.
  - All internal registers cleared.
- FSM states: IDLE, WAIT_REL, MUL_X, MUL_R, FIN.
- IDLE:
  - start=1 moves to WAIT_REL and clears done.
  - Outputs keep the previous result.
- WAIT_REL:
  - Stays while start=1.
  - On the first edge with start=0 (edge 0):
    - capture x into register X;
    - T <= x (term register, 0.16);
    - S <= 65536 + x (18-bit 2.16 sum);
    - i <= 2;
    - go to MUL_X.
- MUL_X: T <= (T*X)>>16 (truncate); go to MUL_R.
- MUL_R:
  - T <= (T*R[i])>>16, where R[i] = floor(65536/i) from a constant table for i = 2..15.
  - S <= S + new T.
  - If i = TERMS-1, go to FIN; otherwise i <= i+1 and go to MUL_X.
- FIN:
  - int_part <= S[17:16], frac_part <= S[15:0], done <= 1.
  - Go to IDLE.
- Latency: done rises at edge 2*(TERMS-2)+1 after edge 0; for TERMS=8 that is edge 13.
- done stays high until the next accepted start.
- x is sampled only at edge 0; later x changes do not affect a running computation.
- start is ignored in MUL_X, MUL_R and FIN; no restart mid-computation.
- Arithmetic:
  - Products are 32-bit, and bits [31:16] are kept.
  - S never exceeds 2.72, so no overflow; int_part is 1 or 2 for all x.
- x=0: every term after the first is 0, so the result is exactly 1.0000.
- Accuracy: within 8 LSB of floor(65536*e^x) for TERMS=8.
- Reset asserted mid-computation aborts it immediately; no done pulse, outputs return to 0.

Optional Feature:
- Macro: EXP_ROUND_EN.
- Defined: both multiply steps round to nearest (add 0x8000 before taking bits [31:16]), and the R[i] table holds round(65536/i). Accuracy tightens to 3 LSB for TERMS=8.
- Undefined: pure truncation as specified above.
- Latency and interface are identical in both builds.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> done=0, int_part=0, frac_part=0; no activity with start=0.
- x=0x0000, start pulsed 5 cycles then released -> done at edge 13 after release; int_part=1, frac_part=0x0000 exactly.
- x=0x4000 (0.25) -> int_part=1, frac_part within 18606..18614 (e^0.25 = 1.2840254); done held high until the next start.
- x=0x2000 (0.125) set while start is high, start released -> int_part=1, frac_part within 8718..8726 (e^0.125 = 1.1331485); the value applied at release is the one used.
- x=0xFFFF -> int_part=2, frac_part within 47060..47073; x toggled after edge 0 does not change the result.
- Reset at edge 6 of a computation -> done stays 0, outputs go to 0; a subsequent start with x=0x4000 completes normally.
